// File: rtl/alu_core.sv
// Registered signed ALU with an iterative restoring divider.
// Latency: 1 cycle for all ops except a normal DIV, which takes WIDTH+1 cycles.
// Backpressure: in_ready is low while a divide is in flight; in_valid is ignored then.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous active-low reset
//   A, B       signed operands
//   Opcode     000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 reserved
//   in_valid   operation present on A/B/Opcode
//   in_ready   block is idle and can take an operation
//   Result     registered result, holds between out_valid pulses
//   Error      registered error flag paired with Result
//   out_valid  one-cycle pulse when Result/Error are updated
module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Opcode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Error,
  output logic             out_valid
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             error_q, error_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH:0]   rem_q, rem_d;    // partial remainder, one spare bit for the trial subtract
  logic [WIDTH-1:0] quo_q, quo_d;    // holds |A| initially; dividend bits shift out as quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;    // |B|
  logic             neg_q, neg_d;    // quotient sign
  logic [CW-1:0]    cnt_q, cnt_d;

  assign in_ready  = (state_q == S_IDLE);
  assign Result    = result_q;
  assign Error     = error_q;
  assign out_valid = out_valid_q;

  // Single-cycle datapath
  logic [WIDTH:0]     add_x, sub_x;
  logic [2*WIDTH-1:0] mul_x;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_err;

  assign add_x    = {A[WIDTH-1], A} + {B[WIDTH-1], B};
  assign sub_x    = {A[WIDTH-1], A} - {B[WIDTH-1], B};
  assign mul_x    = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
  // -MIN_NEG wraps to MIN_NEG, which is the correct unsigned magnitude.
  assign abs_a    = A[WIDTH-1] ? -A : A;
  assign abs_b    = B[WIDTH-1] ? -B : B;
  assign div_zero = (B == '0);
  assign div_ovf  = (A == MIN_NEG) && (B == '1);

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (Opcode)
      3'b000: begin
        alu_res = add_x[WIDTH-1:0];
        alu_err = add_x[WIDTH] ^ add_x[WIDTH-1];
      end
      3'b001: begin
        alu_res = sub_x[WIDTH-1:0];
        alu_err = sub_x[WIDTH] ^ sub_x[WIDTH-1];
      end
      3'b010: begin
        alu_res = mul_x[WIDTH-1:0];
        // Fits in signed WIDTH only if the upper half is a sign extension of bit WIDTH-1.
        alu_err = (mul_x[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){mul_x[WIDTH-1]}});
      end
      3'b011: begin
        // Only the special cases reach Result through this path.
        alu_res = div_ovf ? MIN_NEG : '0;
        alu_err = div_zero | div_ovf;
      end
      3'b100: alu_res = A & B;
      3'b101: alu_res = A | B;
      3'b110: alu_res = A ^ B;
      default: begin
        alu_res = '0;
        alu_err = 1'b1;
      end
    endcase
  end

  // Restoring divider step
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] quo_fix;

  assign rem_sh  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, dvs_q};
  assign quo_fix = neg_q ? -quo_q : quo_q;

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    error_d     = error_q;
    out_valid_d = 1'b0;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_d       = neg_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (Opcode == 3'b011 && !div_zero && !div_ovf) begin
            rem_d   = '0;
            quo_d   = abs_a;
            dvs_d   = abs_b;
            neg_d   = A[WIDTH-1] ^ B[WIDTH-1];
            cnt_d   = CW'(WIDTH);
            state_d = S_BUSY;
          end else begin
            result_d    = alu_res;
            error_d     = alu_err;
            out_valid_d = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (trial[WIDTH]) begin
          rem_d = rem_sh;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_d = trial;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        result_d    = quo_fix;
        error_d     = 1'b0;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      error_q     <= 1'b0;
      out_valid_q <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      error_q     <= error_d;
      out_valid_q <= out_valid_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: table of single-cycle vectors plus divider sequences.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_alu_core;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] A, B;
  logic [2:0]   Opcode;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] Result;
  logic         Error;
  logic         out_valid;

  int nchk = 0;
  int nerr = 0;

  alu_core #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .Opcode(Opcode),
    .in_valid(in_valid), .in_ready(in_ready),
    .Result(Result), .Error(Error), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] res;
    logic         err;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Normal-path divide: checks quotient, error, latency and in_ready-low length.
  // With hold_sub set, a SUB 10-3 is held on the inputs during the busy period
  // and must be accepted on the first idle cycle.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_q, input bit hold_sub, input string name);
    int lat;
    int low;
    bit seen;
    @(negedge clk);
    A = a; B = b; Opcode = 3'b011; in_valid = 1'b1;
    tick();
    low  = (in_ready == 1'b0) ? 1 : 0;
    lat  = 0;
    seen = 1'b0;
    @(negedge clk);
    if (hold_sub) begin
      A = 32'd10; B = 32'd3; Opcode = 3'b001; in_valid = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    for (int k = 0; k < 60; k++) begin
      tick();
      lat++;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      if (!in_ready) low++;
    end
    chk({name, " seen"}, 32'(seen), 32'd1);
    chk({name, " latency"}, 32'(lat), 32'd33);
    chk({name, " in_ready low"}, 32'(low), 32'd33);
    chk({name, " quotient"}, Result, exp_q);
    chk({name, " error"}, 32'(Error), 32'd0);
    if (hold_sub) begin
      tick();
      chk({name, " held sub vld"}, 32'(out_valid), 32'd1);
      chk({name, " held sub res"}, Result, 32'd7);
      @(negedge clk);
      in_valid = 1'b0;
    end
    tick();
    chk({name, " vld drop"}, 32'(out_valid), 32'd0);
  endtask

  vec_t tbl[14];

  initial begin
    int quiet;
    tbl[0]  = '{32'h7FFFFFFF, 32'h00000001, 3'b000, 32'h80000000, 1'b1};
    tbl[1]  = '{32'h80000000, 32'h00000001, 3'b001, 32'h7FFFFFFF, 1'b1};
    tbl[2]  = '{32'h00010000, 32'h00010000, 3'b010, 32'h00000000, 1'b1};
    tbl[3]  = '{32'hFFFFFFFD, 32'h00000007, 3'b010, 32'hFFFFFFEB, 1'b0};
    tbl[4]  = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b100, 32'hF000F000, 1'b0};
    tbl[5]  = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b101, 32'hFFF0FFF0, 1'b0};
    tbl[6]  = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b110, 32'h0FF00FF0, 1'b0};
    tbl[7]  = '{32'h00000009, 32'h00000000, 3'b011, 32'h00000000, 1'b1};
    tbl[8]  = '{32'h80000000, 32'hFFFFFFFF, 3'b011, 32'h80000000, 1'b1};
    tbl[9]  = '{32'h00000001, 32'h00000002, 3'b111, 32'h00000000, 1'b1};
    tbl[10] = '{32'h00000005, 32'hFFFFFFF9, 3'b000, 32'hFFFFFFFE, 1'b0};
    tbl[11] = '{32'hFFFFFFFB, 32'h00000003, 3'b001, 32'hFFFFFFF8, 1'b0};
    tbl[12] = '{32'h80000000, 32'h00000001, 3'b010, 32'h80000000, 1'b0};
    tbl[13] = '{32'hFFFFFFFF, 32'h80000000, 3'b010, 32'h80000000, 1'b1};

    // Reset held with a valid ADD on the inputs: nothing may come out.
    rst = 1'b0; A = 32'd5; B = 32'd7; Opcode = 3'b000; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset Result", Result, 32'd0);
      chk("reset Error", 32'(Error), 32'd0);
      chk("reset out_valid", 32'(out_valid), 32'd0);
    end
    chk("reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("first add vld", 32'(out_valid), 32'd1);
    chk("first add res", Result, 32'd12);
    chk("first add err", 32'(Error), 32'd0);

    // Table vectors issued back-to-back, one accept per cycle.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      A = tbl[i].a; B = tbl[i].b; Opcode = tbl[i].op; in_valid = 1'b1;
      tick();
      chk($sformatf("vec%0d vld", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d res", i), Result, tbl[i].res);
      chk($sformatf("vec%0d err", i), 32'(Error), 32'(tbl[i].err));
    end
    @(negedge clk);
    in_valid = 1'b0;
    A = 32'h12345678;
    tick();
    chk("idle vld drop", 32'(out_valid), 32'd0);
    chk("idle res hold", Result, 32'h80000000);
    chk("idle err hold", 32'(Error), 32'd1);

    run_div(32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 1'b1, "div -100/7");
    run_div(32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, "div 100/-7");
    run_div(32'h80000000, 32'd1, 32'h80000000, 1'b0, "div min/1");
    run_div(32'd7, 32'hFFFFFF9C, 32'd0, 1'b0, "div 7/-100");

    // Reset in the middle of a divide aborts it.
    @(negedge clk);
    A = 32'd1000; B = 32'd3; Opcode = 3'b011; in_valid = 1'b1;
    tick();
    chk("mid accept busy", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("mid rst vld", 32'(out_valid), 32'd0);
    chk("mid rst res", Result, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("mid rst ready", 32'(in_ready), 32'd1);
    quiet = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_valid) quiet++;
    end
    chk("mid rst no pulse", 32'(quiet), 32'd0);
    run_div(32'd1000, 32'd3, 32'd333, 1'b0, "div 1000/3");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Registered signed ALU. It consumes the A/B/Opcode stimulus that the bench drives on the falling clock edge.
- It produces Result/Error, which the bench monitor samples on the rising edge.
- Single-cycle ops have 1-cycle latency. DIV is an iterative restoring divider, and the block back-pressures through in_ready while dividing.
- It is the DUT-side stage that sits directly downstream of the verification interface.

Parameters:
- WIDTH, 32, operand/result width in bits; DIV latency derives from it.

Ports:
- clk        input   1      system clock; all state updates on rising edge
- rst        input   1      reset; synchronous, active-low
- A          input   WIDTH  signed operand A
- B          input   WIDTH  signed operand B
- Opcode     input   3      operation select
- in_valid   input   1      A/B/Opcode valid this cycle
- in_ready   output  1      block can accept an operation
- Result     output  WIDTH  registered result
- Error      output  1      registered error flag for the current Result
- out_valid  output  1      one-cycle pulse: Result/Error updated

Behaviour:
- Reset: rst==0 sampled at posedge gives state=IDLE, Result=0, Error=0, out_valid=0, divider regs=0. in_valid is ignored while rst==0. Reset mid-DIV aborts with no out_valid.
- in_ready = (state==IDLE); combinational from the state register.
- Accept occurs on a posedge with in_valid && in_ready && rst.
- Opcodes (Error=0 unless stated):
  - 000 ADD: A+B mod 2^WIDTH. Error=1 on signed overflow.
  - 001 SUB: A-B mod 2^WIDTH. Error=1 on signed overflow.
  - 010 MUL: low WIDTH bits of the signed 2*WIDTH product. Error=1 if the product does not fit in signed WIDTH.
  - 011 DIV: signed quotient, truncated toward zero.
  - 100 AND.
  - 101 OR.
  - 110 XOR.
  - 111 reserved: Result=0, Error=1.
- Non-DIV latency: accept at edge N gives Result/Error/out_valid=1 after edge N. Back-to-back accepts are allowed (throughput 1/cycle). out_valid falls after the next edge if there is no new accept.
- DIV special cases take the 1-cycle path:
  - B==0: Result=0, Error=1.
  - A==-2^(WIDTH-1) with B==-1: Result=-2^(WIDTH-1), Error=1.
- DIV normal case: on accept, latch |A|, |B|, the quotient sign (A[msb]^B[msb]) and count=WIDTH, then go to DIV_BUSY.
- DIV_BUSY: one quotient bit per cycle, MSB first, restoring (shift remainder, trial subtract, keep if non-negative).
  - After WIDTH iterations go to DIV_DONE.
  - DIV_DONE applies sign correction, registers Result, pulses out_valid, and returns to IDLE.
- DIV total latency: accept at edge N gives out_valid after edge N+WIDTH+1 (33 for WIDTH=32). in_ready=0 for exactly WIDTH+1 cycles.
- in_valid asserted while in_ready==0 is ignored; the producer must hold it.
- Result/Error hold their last value between out_valid pulses.
- FSM states: IDLE, DIV_BUSY, DIV_DONE. No other states are reachable. Any illegal encoding returns to IDLE.
- Arithmetic on internal widths is sized explicitly: WIDTH+1 for ADD/SUB overflow, 2*WIDTH for MUL, WIDTH+1 for the divider remainder.

Test Plan:
- Reset: rst=0 for 3 cycles with in_valid=1, ADD 5,7 -> Result=0, Error=0, out_valid=0 throughout. First accept after release: ADD 5,7 -> Result=12, out_valid one cycle later.
- Overflow: ADD 0x7FFFFFFF,1 -> Result=0x80000000, Error=1. SUB 0x80000000,1 -> Result=0x7FFFFFFF, Error=1. MUL 0x10000,0x10000 -> Result=0, Error=1. MUL -3,7 -> Result=-21, Error=0.
- Back-to-back: AND/OR/XOR of 0xF0F0F0F0 and 0xFF00FF00 on consecutive cycles -> 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0 with out_valid high 3 consecutive cycles.
- DIV: -100/7 -> Result=-14, Error=0, out_valid exactly 33 cycles after accept, in_ready low 33 cycles. An in_valid SUB held during the busy period is accepted on the first cycle in_ready=1.
- DIV corners: 9/0 -> Result=0, Error=1, latency 1. 0x80000000/-1 -> Result=0x80000000, Error=1, latency 1. Opcode 111 -> Result=0, Error=1.
- Reset mid-DIV: start 1000/3, assert rst=0 at cycle 10 -> no out_valid, Result=0, in_ready=1 after release. The next DIV 1000/3 returns 333.
